mult_div_sequencer: RTL and testbench

//  Multicycle signed MULT/DIV engine plus its own sequencer.

---
 rtl/mult_div_sequencer_pkg.sv | 17 +
 rtl/mult_div_datapath.sv | 120 ++++++++++++
 rtl/mult_div_sequencer.sv | 124 ++++++++++++
 tb/tb_mult_div_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mult_div_sequencer_pkg.sv
// rtl/mult_div_sequencer_pkg.sv - shared constants and state encoding for the MULT/DIV engine
// Purpose : default operand/counter widths and the sequencer state type.
// Ports   : none (package).
package mult_div_sequencer_pkg;

    localparam int DEF_WIDTH = 32;  // operand width
    localparam int DEF_CNT_W = 6;   // iteration counter width, 2**CNT_W > WIDTH

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MULT  = 3'd1,
        ST_DIV   = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/mult_div_datapath.sv
// rtl/mult_div_datapath.sv - shared accumulator, operand register, counter and add/sub unit
// Purpose : one-bit-per-clock datapath used by both Booth multiply and restoring divide.
// Ports   : clk_i/reset_ni      clock, synchronous active-low reset
//           load_mult_i         latch multiplicand (op_a_i) and multiplier (op_b_i)
//           load_div_i          latch |op_a_i|, |op_b_i| and the operand signs
//           step_mult_i         one Booth iteration
//           step_div_i          one restoring-division iteration
//           last_o              current step is the final iteration
//           mult_hi_o/mult_lo_o product after the current step (valid on the last step)
//           quo_o/rem_o         sign-corrected quotient/remainder of the finished divide
module mult_div_datapath
    import mult_div_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             load_mult_i,
    input  logic             load_div_i,
    input  logic             step_mult_i,
    input  logic             step_div_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] mult_hi_o,
    output logic [WIDTH-1:0] mult_lo_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    // MULT layout: {P_hi, P_lo, q-1}.  DIV layout: {1'b0, R, Q}.
    logic [2*WIDTH:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand, or divisor magnitude
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q_q, neg_q_d; // quotient must be negated
    logic             neg_r_q, neg_r_d; // remainder must be negated

    logic [WIDTH:0]   p_ext, m_ext, booth_sum;
    logic [2*WIDTH:0] booth_acc;
    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   trial;
    logic [2*WIDTH:0] div_acc;
    logic [WIDTH-1:0] mag_a, mag_b;

    // Booth add/sub is done one bit wider than P_hi so that subtracting
    // INT_MIN cannot overflow before the arithmetic shift.
    always_comb begin
        p_ext = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
        m_ext = {opnd_q[WIDTH-1], opnd_q};
        case (acc_q[1:0])
            2'b01:   booth_sum = p_ext + m_ext;
            2'b10:   booth_sum = p_ext - m_ext;
            default: booth_sum = p_ext;
        endcase
        booth_acc = {booth_sum, acc_q[WIDTH:1]};
    end

    // Restoring step: shifted R fits W+1 bits; a non-negative trial keeps the difference.
    always_comb begin
        shifted = {acc_q[2*WIDTH-1:0], 1'b0};
        trial   = shifted[2*WIDTH:WIDTH] - {1'b0, opnd_q};
        if (!trial[WIDTH]) begin
            div_acc = {1'b0, trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
        end else begin
            div_acc = {1'b0, shifted[2*WIDTH-1:0]};
        end
    end

    assign mag_a = op_a_i[WIDTH-1] ? -op_a_i : op_a_i;
    assign mag_b = op_b_i[WIDTH-1] ? -op_b_i : op_b_i;

    always_comb begin
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        if (load_mult_i) begin
            acc_d  = {{WIDTH{1'b0}}, op_b_i, 1'b0};
            opnd_d = op_a_i;
            cnt_d  = '0;
        end else if (load_div_i) begin
            acc_d   = {1'b0, {WIDTH{1'b0}}, mag_a};
            opnd_d  = mag_b;
            cnt_d   = '0;
            neg_q_d = op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1];
            neg_r_d = op_a_i[WIDTH-1];
        end else if (step_mult_i) begin
            acc_d = booth_acc;
            cnt_d = cnt_q + CNT_W'(1);
        end else if (step_div_i) begin
            acc_d = div_acc;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            acc_q   <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end

    assign last_o    = (cnt_q == CNT_W'(WIDTH - 1));
    assign mult_hi_o = booth_acc[2*WIDTH:WIDTH+1];
    assign mult_lo_o = booth_acc[WIDTH:1];
    assign quo_o     = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_o     = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mult_div_sequencer.sv
// rtl/mult_div_sequencer.sv - multicycle signed MULT/DIV engine with its own sequencer
// Purpose : one-bit-per-clock signed multiply (Booth) and divide (restoring) feeding HI/LO.
// Ports   : clk, reset (sync, active-low)
//           start_mult/start_div  one-cycle requests, honoured in IDLE only (mult wins)
//           op_a/op_b             multiplicand/dividend and multiplier/divisor
//           busy                  operation in flight
//           done                  one-cycle completion pulse; hi_out/lo_out valid from then
//           div_zero_exc          one-cycle pulse for a divide with op_b == 0
//           hi_out/lo_out         MULT: product high/low; DIV: remainder/quotient
module mult_div_sequencer
    import mult_div_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero_exc,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    state_e           state_q;
    logic             busy_q, done_q, dz_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             load_mult, load_div, divisor_zero;
    logic             dp_last;
    logic [WIDTH-1:0] dp_mult_hi, dp_mult_lo, dp_quo, dp_rem;

    assign divisor_zero = (op_b == '0);
    assign load_mult    = (state_q == ST_IDLE) && start_mult;
    assign load_div     = (state_q == ST_IDLE) && !start_mult && start_div && !divisor_zero;

    mult_div_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk_i       (clk),
        .reset_ni    (reset),
        .load_mult_i (load_mult),
        .load_div_i  (load_div),
        .step_mult_i (state_q == ST_MULT),
        .step_div_i  (state_q == ST_DIV),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .last_o      (dp_last),
        .mult_hi_o   (dp_mult_hi),
        .mult_lo_o   (dp_mult_lo),
        .quo_o       (dp_quo),
        .rem_o       (dp_rem)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_mult) begin
                        state_q <= ST_MULT;
                        busy_q  <= 1'b1;
                    end else if (start_div) begin
                        if (divisor_zero) begin
                            dz_q <= 1'b1;
                        end else begin
                            state_q <= ST_DIV;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_MULT: begin
                    // The final Booth step and the HI/LO load share one edge.
                    if (dp_last) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= dp_mult_hi;
                        lo_q    <= dp_mult_lo;
                    end
                end
                ST_DIV: begin
                    if (dp_last) begin
                        state_q <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    hi_q    <= dp_rem;
                    lo_q    <= dp_quo;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign div_zero_exc = dz_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb/tb_mult_div_sequencer.sv - directed self-checking bench for mult_div_sequencer
module tb_mult_div_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] op_a, op_b;
    logic        busy, done, div_zero_exc;
    logic [31:0] hi_out, lo_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_div_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start_mult   (start_mult),
        .start_div    (start_div),
        .op_a         (op_a),
        .op_b         (op_b),
        .busy         (busy),
        .done         (done),
        .div_zero_exc (div_zero_exc),
        .hi_out       (hi_out),
        .lo_out       (lo_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    // Observations from the last run_op window
    int   r_lat, r_done, r_busy, r_dz, r_dz_first;
    logic r_pre_ok;
    logic [31:0] prev_hi, prev_lo;

    // Start at cycle N, then observe cycles N+1..N+40 at the falling edge.
    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_mult = m;
        start_div  = d;
        op_a       = a;
        op_b       = b;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        r_lat = 0; r_done = 0; r_busy = 0; r_dz = 0; r_dz_first = 0; r_pre_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) r_busy++;
            if (div_zero_exc) begin
                r_dz++;
                if (r_dz_first == 0) r_dz_first = k;
            end
            if (done) begin
                r_done++;
                if (r_lat == 0) r_lat = k;
            end
            if (r_lat == 0 && (hi_out !== prev_hi || lo_out !== prev_lo)) r_pre_ok = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
        vecs[1] = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
        vecs[2] = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        vecs[3] = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
        vecs[4] = '{1'b1, 1'b1, 32'd5,        32'd6,        32'h00000000, 32'd30,       33};
        vecs[5] = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 34};
        vecs[6] = '{1'b0, 1'b1, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 34};
        vecs[7] = '{1'b0, 1'b1, 32'h56781234, 32'h00010000, 32'h00001234, 32'h00005678, 34};

        reset = 1'b0; start_mult = 1'b0; start_div = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dz",   {63'd0, div_zero_exc}, 64'd0);
        check("rst_hi",   {32'd0, hi_out}, 64'd0);
        check("rst_lo",   {32'd0, lo_out}, 64'd0);
        reset = 1'b1;
        prev_hi = '0;
        prev_lo = '0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_lat", i),    64'(r_lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_ndone", i),  64'(r_done), 64'd1);
            check($sformatf("v%0d_nbusy", i),  64'(r_busy), 64'(vecs[i].lat - 1));
            check($sformatf("v%0d_ndz", i),    64'(r_dz), 64'd0);
            check($sformatf("v%0d_hold", i),   {63'd0, r_pre_ok}, 64'd1);
            check($sformatf("v%0d_hi", i),     {32'd0, hi_out}, {32'd0, vecs[i].hi});
            check($sformatf("v%0d_lo", i),     {32'd0, lo_out}, {32'd0, vecs[i].lo});
            prev_hi = vecs[i].hi;
            prev_lo = vecs[i].lo;
        end

        // Divide by zero: exception pulse only, HI/LO keep 0x1234/0x5678
        run_op(1'b0, 1'b1, 32'd100, 32'd0);
        check("dz_first", 64'(r_dz_first), 64'd1);
        check("dz_count", 64'(r_dz), 64'd1);
        check("dz_busy",  64'(r_busy), 64'd0);
        check("dz_done",  64'(r_done), 64'd0);
        check("dz_hi",    {32'd0, hi_out}, 64'h1234);
        check("dz_lo",    {32'd0, lo_out}, 64'h5678);

        // Start while busy is ignored; reset mid-operation aborts without done
        @(negedge clk);
        start_mult = 1'b1; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        r_done = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) r_done++;
            if (k == 5) begin
                start_div = 1'b1; op_a = 32'd9; op_b = 32'd3;
            end
            if (k == 6) start_div = 1'b0;
            if (k == 9) check("abort_busy_pre", {63'd0, busy}, 64'd1);
        end
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi",   {32'd0, hi_out}, 64'd0);
        check("abort_lo",   {32'd0, lo_out}, 64'd0);
        reset = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) r_done++;
            if (busy) r_done++;
        end
        check("abort_no_done", 64'(r_done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
